microseq_ctrl: RTL and testbench
================================

MICROSEQ_CTRL -- requirements
Module: microseq_ctrl

Interface
REQ-001 Parameter IRQ_VECTOR, default 'h10, uaddr_t microaddress of interrupt entry routine.
REQ-002 Parameter WAIT_TIMEOUT, default 15, max stall cycles before fault (1..255).
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 uop_cmd  input  microaddr_types::cmd_t  command field of current microinstruction.
REQ-006 uop_addr  input  uaddr_t  address field of current microinstruction.
REQ-007 uop_wait  input  1  current microinstruction needs mem_ready before advancing.
REQ-008 uop_irq_ok  input  1  current microinstruction is an instruction boundary (interrupt point).
REQ-009 mem_ready  input  1  memory access complete.
REQ-010 irq  input  1  interrupt request, level.
REQ-011 halt_req  input  1  halt request, level.
REQ-012 cmd  output  cmd_t  command to microaddress counter.
REQ-013 load_addr  output  uaddr_t  load address to microaddress counter.
REQ-014 irq_ack  output  1  one-cycle pulse when interrupt CALL issued.
REQ-015 depth  output  3  tracked call-stack depth, 0..4.
REQ-016 halted  output  1  high in HALT state.
REQ-017 stack_fault  output  1  high in FAULT state (sticky until reset).
REQ-018 wait_fault  output  1  high in FAULT when cause was timeout.

Function
REQ-019 States RUN, WAIT, HALT, FAULT; cmd/load_addr/irq_ack combinational from state and inputs, same cycle (zero latency).
REQ-020 RUN default: cmd=uop_cmd, load_addr=uop_addr.
REQ-021 RUN priority: halt_req > wait > call-depth check > interrupt > pass-through.
REQ-022 RUN, halt_req=1: cmd=NONE, next HALT.
REQ-023 RUN, uop_wait=1 and mem_ready=0: cmd=NONE, timer cleared to 1, next WAIT; uop_wait=1 with mem_ready=1 executes uop immediately.
REQ-024 WAIT: cmd=NONE while mem_ready=0, timer increments; mem_ready=1: cmd=uop_cmd/uop_addr, next RUN; timer reaching WAIT_TIMEOUT with mem_ready=0: next FAULT, wait_fault set.
REQ-025 Issued CALL (any source) increments depth; issued RET decrements depth; other commands leave depth.
REQ-026 CALL at depth=4 or RET at depth=0: cmd=NONE, next FAULT, stack_fault set, depth unchanged.
REQ-027 Interrupt taken when RUN, irq=1, uop_irq_ok=1, uop_cmd=INC, in_irq=0, depth<4: cmd=CALL, load_addr=IRQ_VECTOR, irq_ack=1; CALL return address addr+1 equals skipped INC target.
REQ-028 uop_irq_ok with uop_cmd other than INC: interrupt not taken, uop passes through.
REQ-029 On interrupt entry: in_irq=1, entry_depth=depth before CALL; RET that brings depth back to entry_depth clears in_irq.
REQ-030 HALT: cmd=NONE, halted=1; halt_req=0 -> next RUN; irq ignored in HALT.
REQ-031 FAULT: cmd=NONE until reset; no exit otherwise.
REQ-032 uop_wait and uop_irq_ok together: wait resolved first; interrupt evaluated only in RUN on the cycle the uop executes.

Reset
REQ-033 reset=1: cmd=NONE, load_addr=0, irq_ack=0 combinationally; next state RUN, depth=0, in_irq=0, entry_depth=0, timer=0, halted=0, stack_fault=0, wait_fault=0.
REQ-034 reset mid-WAIT or mid-interrupt aborts operation with no pending CALL/RET.

Structure
REQ-035 microaddr_types gains uctl_state_t enum (RUN, WAIT, HALT, FAULT) and constant UCALL_DEPTH=4 shared with the microaddress counter.
REQ-036 Single module; no sub-module; drives microaddress counter cmd/load_addr directly.

Verification
REQ-037 Reset, uop_cmd=JMP uop_addr='h22 -> cmd=JMP load_addr='h22 same cycle, depth=0.
REQ-038 uop_wait=1, mem_ready low 3 cycles then high -> cmd=NONE x3, then uop_cmd issued, back to RUN; WAIT_TIMEOUT=4, mem_ready never -> wait_fault=1 after 4 cycles.
REQ-039 Five CALLs without RET -> depth 1,2,3,4, fifth cycle cmd=NONE, stack_fault=1; RET at depth 0 after reset -> stack_fault=1.
REQ-040 irq=1, uop_irq_ok=1, uop_cmd=INC -> cmd=CALL load_addr='h10, irq_ack one cycle, depth 1; second irq blocked until RET returns depth 0.
REQ-041 halt_req with simultaneous irq and uop_wait -> HALT, cmd=NONE; release -> RUN resumes uop.
REQ-042 reset asserted in WAIT with depth=2 -> next cycle RUN, depth=0, faults clear.

Source files
------------

// File: rtl/microaddr_types.sv
// Shared types for the microaddress counter and its sequencing controller.
package microaddr_types;

  typedef logic [7:0] uaddr_t;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    INC  = 3'd1,
    JMP  = 3'd2,
    CALL = 3'd3,
    RET  = 3'd4
  } cmd_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } uctl_state_t;

  // Return-stack depth of the microaddress counter.
  localparam int UCALL_DEPTH = 4;

endpackage

// File: rtl/microseq_ctrl.sv
// Microsequencer control: gates uop commands to the microaddress counter, handling memory waits,
// halt, interrupt entry and call-stack bounds; cmd/load_addr/irq_ack are combinational.
module microseq_ctrl
  import microaddr_types::*;
#(
  parameter uaddr_t IRQ_VECTOR   = 8'h10,
  parameter int     WAIT_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  cmd_t       uop_cmd,
  input  uaddr_t     uop_addr,
  input  logic       uop_wait,
  input  logic       uop_irq_ok,
  input  logic       mem_ready,
  input  logic       irq,
  input  logic       halt_req,
  output cmd_t       cmd,
  output uaddr_t     load_addr,
  output logic       irq_ack,
  output logic [2:0] depth,
  output logic       halted,
  output logic       stack_fault,
  output logic       wait_fault
);

  localparam logic [2:0] DEPTH_MAX = 3'(UCALL_DEPTH);

  uctl_state_t state;
  logic [7:0]  timer;
  logic        in_irq;
  logic [2:0]  entry_depth;

  cmd_t   exec_cmd;
  uaddr_t exec_addr;
  logic   irq_take;
  logic   executes;
  logic   depth_err;

  // Interrupts only enter in RUN so a uop released from WAIT is never replaced by a CALL.
  always_comb begin
    irq_take  = 1'b0;
    exec_cmd  = uop_cmd;
    exec_addr = uop_addr;
    if (state == RUN && irq && uop_irq_ok && uop_cmd == INC && !in_irq && depth < DEPTH_MAX) begin
      irq_take  = 1'b1;
      exec_cmd  = CALL;
      exec_addr = IRQ_VECTOR;
    end
    depth_err = (exec_cmd == CALL && depth == DEPTH_MAX) || (exec_cmd == RET && depth == 3'd0);
    executes  = !reset && ((state == RUN && !halt_req && !(uop_wait && !mem_ready)) ||
                           (state == WAIT && mem_ready));

    cmd       = NONE;
    load_addr = reset ? '0 : uop_addr;
    irq_ack   = 1'b0;
    if (executes && !depth_err) begin
      cmd       = exec_cmd;
      load_addr = exec_addr;
      irq_ack   = irq_take;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      timer       <= '0;
      depth       <= '0;
      in_irq      <= 1'b0;
      entry_depth <= '0;
      halted      <= 1'b0;
      stack_fault <= 1'b0;
      wait_fault  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (halt_req) begin
            state  <= HALT;
            halted <= 1'b1;
          end else if (uop_wait && !mem_ready) begin
            state <= WAIT;
            timer <= 8'd1;
          end
        end
        WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (int'(timer) + 1 >= WAIT_TIMEOUT) begin
            state      <= FAULT;
            wait_fault <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        HALT: begin
          if (!halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: state <= FAULT;
      endcase

      // An out-of-range CALL/RET is suppressed and overrides any transition chosen above.
      if (executes) begin
        if (depth_err) begin
          state       <= FAULT;
          stack_fault <= 1'b1;
        end else if (exec_cmd == CALL) begin
          depth <= depth + 3'd1;
          if (irq_take) begin
            in_irq      <= 1'b1;
            entry_depth <= depth;
          end
        end else if (exec_cmd == RET) begin
          depth <= depth - 3'd1;
          if (in_irq && (depth - 3'd1) == entry_depth) in_irq <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_microseq_ctrl.sv
// Directed bench for microseq_ctrl with hand-computed expectations.
module tb_microseq_ctrl;
  import microaddr_types::*;

  logic       clk = 1'b0;
  logic       reset;
  cmd_t       uop_cmd;
  uaddr_t     uop_addr;
  logic       uop_wait;
  logic       uop_irq_ok;
  logic       mem_ready;
  logic       irq;
  logic       halt_req;
  cmd_t       cmd;
  uaddr_t     load_addr;
  logic       irq_ack;
  logic [2:0] depth;
  logic       halted;
  logic       stack_fault;
  logic       wait_fault;

  int checks = 0;
  int errors = 0;

  microseq_ctrl #(.IRQ_VECTOR(8'h10), .WAIT_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .uop_cmd(uop_cmd), .uop_addr(uop_addr),
    .uop_wait(uop_wait), .uop_irq_ok(uop_irq_ok), .mem_ready(mem_ready),
    .irq(irq), .halt_req(halt_req), .cmd(cmd), .load_addr(load_addr),
    .irq_ack(irq_ack), .depth(depth), .halted(halted),
    .stack_fault(stack_fault), .wait_fault(wait_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_uop(input cmd_t c, input uaddr_t a, input logic w, input logic ok);
    uop_cmd    = c;
    uop_addr   = a;
    uop_wait   = w;
    uop_irq_ok = ok;
    #1;
  endtask

  task automatic do_reset();
    set_uop(NONE, 8'h00, 1'b0, 1'b0);
    mem_ready = 1'b0;
    irq       = 1'b0;
    halt_req  = 1'b0;
    reset     = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    set_uop(JMP, 8'h22, 1'b0, 1'b0);
    mem_ready = 1'b0; irq = 1'b0; halt_req = 1'b0;
    chk("rst_cmd", int'(cmd), int'(NONE));
    chk("rst_addr", int'(load_addr), 0);
    chk("rst_ack", int'(irq_ack), 0);
    tick();
    tick();
    chk("rst_depth", int'(depth), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_sfault", int'(stack_fault), 0);
    chk("rst_wfault", int'(wait_fault), 0);

    // Pass-through
    reset = 1'b0;
    #1;
    chk("jmp_cmd", int'(cmd), int'(JMP));
    chk("jmp_addr", int'(load_addr), 'h22);
    tick();
    chk("jmp_depth", int'(depth), 0);

    // Wait resolved after three stalled cycles
    set_uop(JMP, 8'h33, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("wait_stall%0d", i), int'(cmd), int'(NONE));
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk("wait_rel_cmd", int'(cmd), int'(JMP));
    chk("wait_rel_addr", int'(load_addr), 'h33);
    tick();
    set_uop(JMP, 8'h44, 1'b0, 1'b0);
    chk("wait_back_run", int'(cmd), int'(JMP));
    chk("wait_no_fault", int'(wait_fault), 0);

    // Timeout with WAIT_TIMEOUT=4
    tick();
    set_uop(JMP, 8'h44, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) tick();
    chk("to_not_yet", int'(wait_fault), 0);
    tick();
    chk("to_wfault", int'(wait_fault), 1);
    chk("to_sfault", int'(stack_fault), 0);
    set_uop(JMP, 8'h44, 1'b0, 1'b0);
    chk("to_fault_cmd", int'(cmd), int'(NONE));

    // Five CALLs overflow the stack
    do_reset();
    set_uop(CALL, 8'h40, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("call%0d_cmd", i), int'(cmd), int'(CALL));
      tick();
      chk($sformatf("call%0d_depth", i), int'(depth), i);
    end
    chk("call5_cmd", int'(cmd), int'(NONE));
    tick();
    chk("call5_sfault", int'(stack_fault), 1);
    chk("call5_depth", int'(depth), 4);
    chk("call5_wfault", int'(wait_fault), 0);

    // RET at depth 0
    do_reset();
    chk("reset_clears_sfault", int'(stack_fault), 0);
    set_uop(RET, 8'h00, 1'b0, 1'b0);
    chk("ret0_cmd", int'(cmd), int'(NONE));
    tick();
    chk("ret0_sfault", int'(stack_fault), 1);
    chk("ret0_depth", int'(depth), 0);

    // Interrupt entry and re-arm
    do_reset();
    irq = 1'b1;
    set_uop(JMP, 8'h07, 1'b0, 1'b1);
    chk("irq_non_inc_cmd", int'(cmd), int'(JMP));
    chk("irq_non_inc_ack", int'(irq_ack), 0);
    tick();
    set_uop(INC, 8'h05, 1'b0, 1'b1);
    chk("irq_cmd", int'(cmd), int'(CALL));
    chk("irq_addr", int'(load_addr), 'h10);
    chk("irq_ack", int'(irq_ack), 1);
    tick();
    chk("irq_depth", int'(depth), 1);
    chk("irq2_blocked_cmd", int'(cmd), int'(INC));
    chk("irq2_blocked_ack", int'(irq_ack), 0);
    tick();
    set_uop(RET, 8'h00, 1'b0, 1'b0);
    chk("irq_ret_cmd", int'(cmd), int'(RET));
    tick();
    chk("irq_ret_depth", int'(depth), 0);
    set_uop(INC, 8'h09, 1'b0, 1'b1);
    chk("irq_rearm_cmd", int'(cmd), int'(CALL));
    chk("irq_rearm_ack", int'(irq_ack), 1);
    tick();
    chk("irq_rearm_depth", int'(depth), 1);

    // Wait plus interrupt point: released uop is not replaced by an interrupt CALL
    do_reset();
    irq = 1'b1;
    set_uop(INC, 8'h0a, 1'b1, 1'b1);
    chk("wirq_stall_cmd", int'(cmd), int'(NONE));
    chk("wirq_stall_ack", int'(irq_ack), 0);
    tick();
    mem_ready = 1'b1;
    #1;
    chk("wirq_rel_cmd", int'(cmd), int'(INC));
    chk("wirq_rel_ack", int'(irq_ack), 0);
    tick();
    chk("wirq_depth", int'(depth), 0);

    // Halt has priority over wait and interrupt
    do_reset();
    halt_req = 1'b1; irq = 1'b1;
    set_uop(INC, 8'h0b, 1'b1, 1'b1);
    chk("halt_cmd", int'(cmd), int'(NONE));
    chk("halt_ack", int'(irq_ack), 0);
    tick();
    chk("halt_halted", int'(halted), 1);
    chk("halt_hold_cmd", int'(cmd), int'(NONE));
    tick();
    halt_req = 1'b0; irq = 1'b0;
    set_uop(JMP, 8'h55, 1'b0, 1'b0);
    chk("halt_rel_cmd", int'(cmd), int'(NONE));
    tick();
    chk("halt_rel_halted", int'(halted), 0);
    chk("halt_resume_cmd", int'(cmd), int'(JMP));
    chk("halt_resume_addr", int'(load_addr), 'h55);

    // Reset while waiting at depth 2
    do_reset();
    set_uop(CALL, 8'h30, 1'b0, 1'b0);
    tick();
    tick();
    set_uop(RET, 8'h00, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    tick();
    chk("rw_depth", int'(depth), 2);
    reset = 1'b1;
    mem_ready = 1'b1;
    #1;
    chk("rw_rst_cmd", int'(cmd), int'(NONE));
    tick();
    reset = 1'b0;
    set_uop(JMP, 8'h66, 1'b0, 1'b0);
    chk("rw_depth0", int'(depth), 0);
    chk("rw_sfault", int'(stack_fault), 0);
    chk("rw_wfault", int'(wait_fault), 0);
    chk("rw_run_cmd", int'(cmd), int'(JMP));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
